// File: rtl/wb_write_arbiter_pkg.sv
// Shared writeback-entry layout and register-index helper for the writeback arbiter.
package wb_write_arbiter_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int FP_BANK_OFFSET = 32;
    localparam int WB_ENTRY_W     = 38;
    localparam int REG_IDX_W      = 6;

    typedef struct packed {
        logic                  isFloat;
        logic [REG_ADDR_W-1:0] wa;
        logic [31:0]           wd;
    } wbEntry_t;

    // Flat 0..63 register index; FP bank sits above the integer bank.
    function automatic logic [REG_IDX_W-1:0] regIndex(input logic isFloat,
                                                      input logic [REG_ADDR_W-1:0] wa);
        return (isFloat ? REG_IDX_W'(FP_BANK_OFFSET) : '0) + REG_IDX_W'(wa);
    endfunction

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Circular buffer of queued long-latency results; 1-cycle enqueue-to-head, no bypass.
// Caller must not push when full or pop when empty; per-entry valid/tag feed the hazard compare.
module wb_write_arbiter_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  wbEntry_t             pushEntry,
    input  logic                 pop,
    output wbEntry_t             headEntry,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH-1:0]     entryValid,
    output logic [REG_IDX_W-1:0] entryTag [DEPTH]
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WB_ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W:0]        count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[tail] <= pushEntry;
    end

    assign headEntry = wbEntry_t'(mem[head]);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);

    // Slot i is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entryValid[i] = ({1'b0, PTR_W'(i) - head} < count);
            entryTag[i]   = regIndex(mem[i][WB_ENTRY_W-1],
                                     mem[i][WB_ENTRY_W-2 -: REG_ADDR_W]);
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges pipeline writeback (absolute priority, 0-cycle mux) with queued long-latency results.
// mc_ready drops when the FIFO is full; optional WBARB_STARVE_EN raises drain_req after a long wait.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_wen,
    input  logic [4:0]  wb_wa,
    input  logic        wb_float,
    input  logic [31:0] wb_wd,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_wa,
    input  logic        mc_float,
    input  logic [31:0] mc_wd,
    input  logic [4:0]  q_raA,
    input  logic [4:0]  q_raB,
    input  logic        q_float,
    output logic        q_hitA,
    output logic        q_hitB,
    output logic        rf_wen,
    output logic [4:0]  rf_wa,
    output logic        rf_float,
    output logic [31:0] rf_wd,
    output logic        drain_req
);
    wbEntry_t             headEntry;
    wbEntry_t             pushEntry;
    logic                 full;
    logic                 empty;
    logic                 wbLive;
    logic                 doPush;
    logic                 doPop;
    logic [DEPTH-1:0]     entryValid;
    logic [REG_IDX_W-1:0] entryTag [DEPTH];
    logic [REG_IDX_W-1:0] tagA;
    logic [REG_IDX_W-1:0] tagB;
    logic                 matchA;
    logic                 matchB;

    // A pipeline write to r0 is a free slot for the FIFO.
    assign wbLive    = wb_wen && (wb_wa != '0);
    assign mc_ready  = reset && !full;
    assign doPush    = mc_valid && mc_ready && (mc_wa != '0);
    assign doPop     = reset && !wbLive && !empty;
    assign pushEntry = '{isFloat: mc_float, wa: mc_wa, wd: mc_wd};

    wb_write_arbiter_fifo #(.DEPTH(DEPTH)) fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (doPush),
        .pushEntry  (pushEntry),
        .pop        (doPop),
        .headEntry  (headEntry),
        .full       (full),
        .empty      (empty),
        .entryValid (entryValid),
        .entryTag   (entryTag)
    );

    always_comb begin
        rf_wen   = 1'b0;
        rf_wa    = '0;
        rf_float = 1'b0;
        rf_wd    = '0;
        if (reset) begin
            if (wbLive) begin
                rf_wen   = 1'b1;
                rf_wa    = wb_wa;
                rf_float = wb_float;
                rf_wd    = wb_wd;
            end else if (!empty) begin
                rf_wen   = 1'b1;
                rf_wa    = headEntry.wa;
                rf_float = headEntry.isFloat;
                rf_wd    = headEntry.wd;
            end
        end
    end

    // The head still reports a hit in its drain cycle; RegFile bypass covers that cycle.
    always_comb begin
        tagA   = regIndex(q_float, q_raA);
        tagB   = regIndex(q_float, q_raB);
        matchA = 1'b0;
        matchB = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && entryTag[i] == tagA) matchA = 1'b1;
            if (entryValid[i] && entryTag[i] == tagB) matchB = 1'b1;
        end
    end

    assign q_hitA = reset && (q_raA != '0) && matchA;
    assign q_hitB = reset && (q_raB != '0) && matchB;

`ifdef WBARB_STARVE_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starveCnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            starveCnt <= '0;
        end else if (doPop || empty) begin
            starveCnt <= '0;
        end else if (wbLive && starveCnt < SC_W'(STARVE_LIMIT)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    assign drain_req = reset && (starveCnt >= SC_W'(STARVE_LIMIT));
`else
    assign drain_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed + randomized bench for wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        wbWen = 1'b0;
    logic [4:0]  wbWa = '0;
    logic        wbFloat = 1'b0;
    logic [31:0] wbWd = '0;
    logic        mcValid = 1'b0;
    logic        mcReady;
    logic [4:0]  mcWa = '0;
    logic        mcFloat = 1'b0;
    logic [31:0] mcWd = '0;
    logic [4:0]  qRaA = '0;
    logic [4:0]  qRaB = '0;
    logic        qFloat = 1'b0;
    logic        qHitA;
    logic        qHitB;
    logic        rfWen;
    logic [4:0]  rfWa;
    logic        rfFloat;
    logic [31:0] rfWd;
    logic        drainReq;

    typedef struct {
        logic        f;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t refQ[$];
    int   starve = 0;
    int   tests = 0;
    int   failures = 0;

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock     (clock),
        .reset     (rst),
        .wb_wen    (wbWen),
        .wb_wa     (wbWa),
        .wb_float  (wbFloat),
        .wb_wd     (wbWd),
        .mc_valid  (mcValid),
        .mc_ready  (mcReady),
        .mc_wa     (mcWa),
        .mc_float  (mcFloat),
        .mc_wd     (mcWd),
        .q_raA     (qRaA),
        .q_raB     (qRaB),
        .q_float   (qFloat),
        .q_hitA    (qHitA),
        .q_hitB    (qHitB),
        .rf_wen    (rfWen),
        .rf_wa     (rfWa),
        .rf_float  (rfFloat),
        .rf_wd     (rfWd),
        .drain_req (drainReq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic refHit(input logic [4:0] ra);
        if (!rst || ra == 0) return 1'b0;
        foreach (refQ[k])
            if (refQ[k].f == qFloat && refQ[k].wa == ra) return 1'b1;
        return 1'b0;
    endfunction

    // Expected outputs from the queue contents and current inputs.
    task automatic checkOutputs(input string tag);
        logic        live;
        logic        eWen;
        logic [4:0]  eWa;
        logic        eF;
        logic [31:0] eWd;
        logic        eDrain;
        live = wbWen && wbWa != 0;
        eWen = rst && (live || refQ.size() > 0);
        eWa = '0; eF = 1'b0; eWd = '0;
        if (live) begin
            eWa = wbWa; eF = wbFloat; eWd = wbWd;
        end else if (refQ.size() > 0) begin
            eWa = refQ[0].wa; eF = refQ[0].f; eWd = refQ[0].wd;
        end
        eDrain = 1'b0;
`ifdef WBARB_STARVE_EN
        eDrain = rst && starve >= LIMIT;
`endif
        chk({tag, ".rf_wen"}, rfWen, eWen);
        chk({tag, ".mc_ready"}, mcReady, rst && refQ.size() < DEPTH);
        chk({tag, ".q_hitA"}, qHitA, refHit(qRaA));
        chk({tag, ".q_hitB"}, qHitB, refHit(qRaB));
        chk({tag, ".drain_req"}, drainReq, eDrain);
        if (rst && eWen) begin
            chk({tag, ".rf_wa"}, rfWa, eWa);
            chk({tag, ".rf_float"}, rfFloat, eF);
            chk({tag, ".rf_wd"}, rfWd, eWd);
        end
    endtask

    task automatic modelEdge();
        logic live;
        logic doPop;
        logic doPush;
        int   sz;
        live = wbWen && wbWa != 0;
        sz = refQ.size();
        if (!rst) begin
            refQ.delete();
            starve = 0;
            return;
        end
        doPop = !live && sz > 0;
        doPush = mcValid && sz < DEPTH && mcWa != 0;
        if (doPop || sz == 0) starve = 0;
        else if (live && starve < LIMIT) starve++;
        if (doPop) void'(refQ.pop_front());
        if (doPush) refQ.push_back('{mcFloat, mcWa, mcWd});
    endtask

    task automatic cycle(input string tag);
        #1;
        checkOutputs(tag);
        @(posedge clock);
        modelEdge();
        @(negedge clock);
    endtask

    initial begin
        int   order[4];
        logic expDrain;
        order = '{12, 13, 14, 15};

        // Reset held with a result offered.
        rst = 1'b0; mcValid = 1'b1; mcWa = 5'd4; mcWd = 32'h1234;
        @(posedge clock); modelEdge(); @(negedge clock);
        #1 chk("reset.mc_ready", mcReady, 1'b0);
        chk("reset.rf_wen", rfWen, 1'b0);
        cycle("reset1");
        cycle("reset2");
        rst = 1'b1; mcValid = 1'b0;
        #1 chk("release.mc_ready", mcReady, 1'b1);
        chk("release.rf_wen", rfWen, 1'b0);
        cycle("release");

        // Pipeline writeback passes through in the same cycle.
        wbWen = 1'b1; wbWa = 5'd5; wbFloat = 1'b0; wbWd = 32'hA5A5_0001;
        #1 chk("wb.rf_wen", rfWen, 1'b1);
        chk("wb.rf_wa", rfWa, 5'd5);
        chk("wb.rf_wd", rfWd, 32'hA5A5_0001);
        cycle("wb");

        // Queued FP result waits behind pipeline writes, then drains.
        mcValid = 1'b1; mcWa = 5'd3; mcFloat = 1'b1; mcWd = 32'h3F80_0000;
        wbWa = 5'd7; qRaA = 5'd3; qFloat = 1'b1; qRaB = 5'd3;
        cycle("hold0");
        mcValid = 1'b0; qRaB = 5'd0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("hold.q_hitA", qHitA, 1'b1);
            cycle("hold");
        end
        wbWen = 1'b0;
        #1 chk("drain.rf_wa", rfWa, 5'd3);
        chk("drain.rf_float", rfFloat, 1'b1);
        chk("drain.q_hitA", qHitA, 1'b1);
        cycle("drain");
        #1 chk("after.q_hitA", qHitA, 1'b0);
        cycle("after");

        // Fill to DEPTH, push+pop, then check arrival order.
        wbWen = 1'b1; wbWa = 5'd7; qFloat = 1'b0; qRaA = 5'd12; qRaB = 5'd13;
        for (int i = 0; i < DEPTH; i++) begin
            mcValid = 1'b1; mcWa = 5'(10 + i); mcFloat = 1'b0; mcWd = 32'h1000 + i;
            cycle("fill");
        end
        mcWa = 5'd20;
        #1 chk("full.mc_ready", mcReady, 1'b0);
        cycle("full");
        mcValid = 1'b0; wbWen = 1'b0;
        #1 chk("pop.rf_wa", rfWa, 5'd10);
        cycle("pop");
        mcValid = 1'b1; mcWa = 5'd14; mcWd = 32'h1004;
        #1 chk("pushpop.rf_wa", rfWa, 5'd11);
        chk("pushpop.mc_ready", mcReady, 1'b1);
        cycle("pushpop");
        wbWen = 1'b1; mcWa = 5'd15; mcWd = 32'h1005;
        #1 chk("refill.mc_ready", mcReady, 1'b1);
        cycle("refill");
        mcValid = 1'b0; wbWen = 1'b0;
        #1 chk("refilled.mc_ready", mcReady, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1 chk("order.rf_wa", rfWa, order[k]);
            cycle("order");
        end

        // r0 results are discarded; a pipeline write to r0 frees the slot.
        mcValid = 1'b1; mcWa = 5'd0; mcWd = 32'hDEAD;
        #1 chk("r0mc.mc_ready", mcReady, 1'b1);
        cycle("r0mc");
        mcValid = 1'b0;
        #1 chk("r0mc.rf_wen", rfWen, 1'b0);
        cycle("r0mc_empty");
        mcValid = 1'b1; mcWa = 5'd9; mcWd = 32'h9999; wbWen = 1'b1; wbWa = 5'd7;
        cycle("r0push");
        mcValid = 1'b0; wbWa = 5'd0;
        #1 chk("r0wb.rf_wen", rfWen, 1'b1);
        chk("r0wb.rf_wa", rfWa, 5'd9);
        cycle("r0wb");

        // Long starvation under continuous writeback, then one bubble.
        mcValid = 1'b1; mcWa = 5'd6; mcWd = 32'h6666; wbWa = 5'd7;
        cycle("starvepush");
        mcValid = 1'b0;
        for (int j = 0; j < 11; j++) begin
            expDrain = 1'b0;
`ifdef WBARB_STARVE_EN
            expDrain = (j >= LIMIT);
`endif
            #1 chk("starve.drain_req", drainReq, expDrain);
            cycle("starve");
        end
        wbWen = 1'b0;
        #1 chk("bubble.rf_wa", rfWa, 5'd6);
        cycle("bubble");
        #1 chk("bubble.drain_req", drainReq, 1'b0);
        cycle("postbubble");

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) != 0);
            wbWen   = ($urandom_range(0, 9) < 6);
            wbWa    = 5'($urandom_range(0, 7));
            wbFloat = 1'($urandom);
            wbWd    = $urandom;
            mcValid = 1'($urandom);
            mcWa    = 5'($urandom_range(0, 7));
            mcFloat = 1'($urandom);
            mcWd    = $urandom;
            qRaA    = 5'($urandom_range(0, 7));
            qRaB    = 5'($urandom_range(0, 7));
            qFloat  = 1'($urandom);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
